mips_ctrl_fsm: RTL
==================

MIPS_CTRL_FSM -- requirements
Module: mips_ctrl_fsm

Interface
REQ-001 Parameter MUL_CYCLES, default 4, meaning: EXEC2 cycles held for MULT/MULTU (>=1).
REQ-002 Parameter DIV_CYCLES, default 32, meaning: EXEC2 cycles held for DIV/DIVU (>=1).
REQ-003 Parameter CNT_W, default 6, meaning: stall counter width; it SHALL hold max(MUL_CYCLES, DIV_CYCLES).
REQ-004 clk  input  1  single system clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset; sampled on the clk rising edge.
REQ-006 readdata  input  32  memory read data; the instruction word during FETCH.
REQ-007 waitrequest  input  1  memory busy; the current access SHALL be held while high.
REQ-008 pc  input  32  address of the current instruction.
REQ-009 branch_cond  input  1  branch condition from the ALU, valid in EXEC1.
REQ-010 addr_lo  input  2  effective-address bits [1:0] of a load/store, valid in EXEC1.
REQ-011 state  output  2  FETCH=00, EXEC1=01, EXEC2=10, HALT=11.
REQ-012 ir  output  32  latched instruction register.
REQ-013 active  output  1  high unless in HALT.
REQ-014 mem_read, mem_write  output  1 each  memory strobes.
REQ-015 byteenable  output  4  memory byte lanes.
REQ-016 reg_write  output  1  register-file write strobe.
REQ-017 pc_en  output  1  one-cycle PC update strobe.
REQ-018 is_branch  output  1  a jump or taken branch, qualified with pc_en.
REQ-019 muldiv_start  output  1  one-cycle start pulse to the mul/div unit.
REQ-020 muldiv_busy  output  1  high while the stall counter is nonzero.
REQ-021 addr_err  output  1  sticky misaligned-access flag.

Function
REQ-022 Decode SHALL use ir[31:26], ir[5:0] (SPECIAL) and ir[20:16] (REGIMM), with the standard MIPS-I encodings.
REQ-023 FETCH: mem_read=1, byteenable=1111. If pc==0, next state is HALT. Else, if waitrequest=1, stay in FETCH. Else load ir<=readdata and go to EXEC1.
REQ-024 EXEC1 load (LB/LBU/LH/LHU/LW/LWL/LWR): mem_read=1; hold while waitrequest=1; then go to EXEC2.
REQ-025 EXEC1 store (SB/SH/SW): mem_write=1; hold while waitrequest=1; then pc_en=1 and go to FETCH.
REQ-026 EXEC1 MULT/MULTU/DIV/DIVU: muldiv_start=1 for exactly one cycle; counter<=MUL_CYCLES or DIV_CYCLES; go to EXEC2.
REQ-027 EXEC1 all other instructions: pc_en=1 and go to FETCH in one cycle.
REQ-028 EXEC1 reg_write SHALL be high for ALU/shift/MFHI/MFLO/JALR/JAL, and for BGEZAL/BLTZAL only when branch_cond=1.
REQ-029 is_branch SHALL be high for J/JAL/JR/JALR, and for conditional branches when branch_cond=1.
REQ-030 Byte enables: LB/LBU/SB => 4'b0001<<addr_lo; LH/LHU/SH => addr_lo[1] ? 1100 : 0011; LW/SW/LWL/LWR => 1111.
REQ-031 LH/LHU/SH with addr_lo[0]=1, or LW/SW with addr_lo!=00: suppress the strobes, set addr_err=1, go to HALT.
REQ-032 EXEC2 load: reg_write=1 and pc_en=1, then go to FETCH.
REQ-033 EXEC2 mul/div: counter decrements each cycle; when the counter reaches 1, pc_en=1 and go to FETCH next; muldiv_busy falls with the counter at 0.
REQ-034 A parameter value of 1 SHALL give exactly one EXEC2 cycle.
REQ-035 HALT: sticky until reset; all strobes 0; active=0; ir holds its value.
REQ-036 Every strobe output SHALL be combinational from state and ir; state, ir, counter and addr_err SHALL be registered.
REQ-037 Undefined opcodes SHALL behave as NOP: EXEC1 -> FETCH with pc_en=1 and no writes.

Reset
REQ-038 Reset SHALL take priority over every other event, including waitrequest, an in-flight store, or the stall counter.
REQ-039 On the cycle after reset is sampled high: state=FETCH, ir=0, counter=0, addr_err=0, active=1, and all strobes except FETCH's mem_read are 0.
REQ-040 A reset asserted during EXEC1 with mem_write=1 SHALL leave mem_write=0 from the next cycle.

Verification
REQ-041 pc=0x400, readdata=0x24020005 (ADDIU), waitrequest low for 2 cycles -> FETCH, EXEC1 with reg_write=1 and pc_en=1, then FETCH.
REQ-042 LW with waitrequest high for 3 EXEC1 cycles -> mem_read held for 4 cycles, then EXEC2 with reg_write=1 and pc_en=1.
REQ-043 DIV with DIV_CYCLES=32 -> muldiv_start for 1 cycle, muldiv_busy for 32 cycles, pc_en on the last EXEC2 cycle; total 34 cycles per instruction.
REQ-044 SB with addr_lo=2 -> byteenable=0100. SH with addr_lo=1 -> addr_err=1, no mem_write, state=HALT.
REQ-045 pc=0 in FETCH -> HALT and active=0 from the next cycle, held for 10 cycles; then reset -> FETCH.
REQ-046 Reset mid-MULT (counter=2) -> next cycle state=FETCH and muldiv_busy=0.

Source files
------------

// File: rtl/mips_ctrl_fsm.sv
// Multi-cycle MIPS-I control sequencer: FETCH / EXEC1 / EXEC2 / HALT.
// Registers state, ir, the mul/div stall counter and the sticky alignment error.
module mips_ctrl_fsm #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] readdata,
    input  logic        waitrequest,
    input  logic [31:0] pc,
    input  logic        branch_cond,
    input  logic [1:0]  addr_lo,
    output logic [1:0]  state,
    output logic [31:0] ir,
    output logic        active,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  byteenable,
    output logic        reg_write,
    output logic        pc_en,
    output logic        is_branch,
    output logic        muldiv_start,
    output logic        muldiv_busy,
    output logic        addr_err
);

    localparam logic [1:0] S_FETCH = 2'b00;
    localparam logic [1:0] S_EXEC1 = 2'b01;
    localparam logic [1:0] S_EXEC2 = 2'b10;
    localparam logic [1:0] S_HALT  = 2'b11;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LWL     = 6'h22;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_LWR     = 6'h26;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    localparam logic [4:0] RT_BLTZ   = 5'h00;
    localparam logic [4:0] RT_BGEZ   = 5'h01;
    localparam logic [4:0] RT_BLTZAL = 5'h10;
    localparam logic [4:0] RT_BGEZAL = 5'h11;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       state_reg, state_next;
    logic [31:0]      ir_reg, ir_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             addr_err_reg, addr_err_next;

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rt;

    assign op    = ir_reg[31:26];
    assign funct = ir_reg[5:0];
    assign rt    = ir_reg[20:16];

    logic is_special, is_regimm;
    logic dec_load, dec_store, dec_byte, dec_half, dec_word_strict;
    logic dec_mul, dec_div, dec_muldiv;
    logic dec_r_write, dec_i_alu;
    logic dec_jr, dec_jalr, dec_j, dec_jal;
    logic dec_cbranch, dec_link_branch;
    logic misaligned;

    assign is_special = (op == OP_SPECIAL);
    assign is_regimm  = (op == OP_REGIMM);

    assign dec_load  = (op == OP_LB)  || (op == OP_LH)  || (op == OP_LWL) ||
                       (op == OP_LW)  || (op == OP_LBU) || (op == OP_LHU) ||
                       (op == OP_LWR);
    assign dec_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);

    assign dec_byte        = (op == OP_LB) || (op == OP_LBU) || (op == OP_SB);
    assign dec_half        = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    // LWL/LWR are intentionally unaligned; only LW/SW demand word alignment.
    assign dec_word_strict = (op == OP_LW) || (op == OP_SW);

    assign dec_mul    = is_special && ((funct == FN_MULT) || (funct == FN_MULTU));
    assign dec_div    = is_special && ((funct == FN_DIV)  || (funct == FN_DIVU));
    assign dec_muldiv = dec_mul || dec_div;

    assign dec_r_write = is_special && (
                             (funct == FN_SLL)  || (funct == FN_SRL)  ||
                             (funct == FN_SRA)  || (funct == FN_SLLV) ||
                             (funct == FN_SRLV) || (funct == FN_SRAV) ||
                             (funct == FN_MFHI) || (funct == FN_MFLO) ||
                             (funct == FN_JALR) ||
                             ((funct >= FN_ADD) && (funct <= FN_NOR)) ||
                             (funct == FN_SLT)  || (funct == FN_SLTU));
    assign dec_i_alu = (op >= OP_ADDI) && (op <= OP_LUI);

    assign dec_jr   = is_special && (funct == FN_JR);
    assign dec_jalr = is_special && (funct == FN_JALR);
    assign dec_j    = (op == OP_J);
    assign dec_jal  = (op == OP_JAL);

    assign dec_link_branch = is_regimm && ((rt == RT_BLTZAL) || (rt == RT_BGEZAL));
    assign dec_cbranch     = (op == OP_BEQ) || (op == OP_BNE) ||
                             (op == OP_BLEZ) || (op == OP_BGTZ) ||
                             (is_regimm && ((rt == RT_BLTZ) || (rt == RT_BGEZ))) ||
                             dec_link_branch;

    assign misaligned = (dec_half && addr_lo[0]) ||
                        (dec_word_strict && (addr_lo != 2'b00));

    // One-hot byte lane selected by the low address bits.
    logic [3:0] lane_byte;
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_byte[gi] = (addr_lo == 2'(gi));
        end
    endgenerate

    logic [3:0] access_be;
    always_comb begin
        access_be = 4'b1111;
        if (dec_byte) begin
            access_be = lane_byte;
        end else if (dec_half) begin
            access_be = addr_lo[1] ? 4'b1100 : 4'b0011;
        end
    end

    always_comb begin
        state_next    = state_reg;
        ir_next       = ir_reg;
        cnt_next      = cnt_reg;
        addr_err_next = addr_err_reg;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        byteenable    = 4'b0000;
        reg_write     = 1'b0;
        pc_en         = 1'b0;
        is_branch     = 1'b0;
        muldiv_start  = 1'b0;

        case (state_reg)
            S_FETCH: begin
                mem_read   = 1'b1;
                byteenable = 4'b1111;
                if (pc == 32'h0) begin
                    state_next = S_HALT;
                end else if (!waitrequest) begin
                    ir_next    = readdata;
                    state_next = S_EXEC1;
                end
            end

            S_EXEC1: begin
                if ((dec_load || dec_store) && misaligned) begin
                    addr_err_next = 1'b1;
                    state_next    = S_HALT;
                end else if (dec_load) begin
                    mem_read   = 1'b1;
                    byteenable = access_be;
                    if (!waitrequest) begin
                        state_next = S_EXEC2;
                    end
                end else if (dec_store) begin
                    mem_write  = 1'b1;
                    byteenable = access_be;
                    if (!waitrequest) begin
                        pc_en      = 1'b1;
                        state_next = S_FETCH;
                    end
                end else if (dec_muldiv) begin
                    muldiv_start = 1'b1;
                    cnt_next     = dec_div ? DIV_LOAD : MUL_LOAD;
                    state_next   = S_EXEC2;
                end else begin
                    // ALU, jumps, branches and undefined opcodes all retire here.
                    pc_en      = 1'b1;
                    reg_write  = dec_r_write || dec_i_alu || dec_jal ||
                                 (dec_link_branch && branch_cond);
                    is_branch  = dec_j || dec_jal || dec_jr || dec_jalr ||
                                 (dec_cbranch && branch_cond);
                    state_next = S_FETCH;
                end
            end

            S_EXEC2: begin
                if (dec_muldiv) begin
                    if (cnt_reg != '0) begin
                        cnt_next = cnt_reg - CNT_ONE;
                    end
                    if (cnt_reg <= CNT_ONE) begin
                        pc_en      = 1'b1;
                        state_next = S_FETCH;
                    end
                end else begin
                    reg_write  = 1'b1;
                    pc_en      = 1'b1;
                    state_next = S_FETCH;
                end
            end

            default: begin
                state_next = S_HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_FETCH;
            ir_reg       <= 32'h0;
            cnt_reg      <= '0;
            addr_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ir_reg       <= ir_next;
            cnt_reg      <= cnt_next;
            addr_err_reg <= addr_err_next;
        end
    end

    assign state       = state_reg;
    assign ir          = ir_reg;
    assign active      = (state_reg != S_HALT);
    assign muldiv_busy = (cnt_reg != '0);
    assign addr_err    = addr_err_reg;

endmodule
